// File: rtl/arbiter_control.sv
// Sequencing FSM that arbitrates I-cache and D-cache misses onto one physical-memory port.
// Optional grant/contention performance counters are built when ARB_PERF_EN is defined.
module arbiter_control #(
  parameter int ARB_MODE     = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iread,
  input  logic                 dread,
  input  logic                 dwrite,
  input  logic                 pmem_resp,
  output logic                 cache_sel,
  output logic                 mem_en,
  output logic                 busy,
  output logic                 spurious_resp,
`ifdef ARB_PERF_EN
  output logic [CNT_WIDTH-1:0] i_grant_cnt,
  output logic [CNT_WIDTH-1:0] d_grant_cnt,
  output logic [CNT_WIDTH-1:0] contention_cnt,
`endif
  output logic [1:0]           state_dbg
);

  // Handshake: a cache holds its request until it sees its pmem_resp pulse; ownership of
  // pmem is granted by the IDLE->SERVE_x transition and released on pmem_resp.

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_I    = 2'd1,
    SERVE_D    = 2'd2,
    TURNAROUND = 2'd3
  } state_t;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
    $error("arbiter_control: STARVE_LIMIT must be >= 1");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("arbiter_control: CNT_WIDTH must be >= 1");
  end

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;   // 0 = I, 1 = D
  logic [SW-1:0] starve_q, starve_d;
  logic          cache_sel_q;
  logic          spurious_q;
  logic          ireq, dreq, tie;
  logic          grant_i, grant_d;

  assign ireq = iread;
  assign dreq = dread | dwrite;
  assign tie  = ireq & dreq;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    starve_d     = starve_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tie) begin
          if (ARB_MODE == 0) begin
            grant_i = last_grant_q;
            grant_d = ~last_grant_q;
          end else if (starve_q == STARVE_MAX) begin
            grant_i = 1'b1;
          end else begin
            grant_d  = 1'b1;
            starve_d = starve_q + 1'b1;
          end
        end else if (ireq) begin
          grant_i = 1'b1;
        end else if (dreq) begin
          grant_d = 1'b1;
        end
        if (grant_i) begin
          state_d  = SERVE_I;
          starve_d = '0;
        end else if (grant_d) begin
          state_d = SERVE_D;
        end
      end
      // Memory is committed once granted: requests are ignored until the response.
      SERVE_I: begin
        if (pmem_resp) begin
          state_d      = TURNAROUND;
          last_grant_d = 1'b0;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d      = TURNAROUND;
          last_grant_d = 1'b1;
        end
      end
      TURNAROUND: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      starve_q     <= '0;
      cache_sel_q  <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
      // Registered select only moves at a grant, so it cannot glitch mid-transaction.
      if (grant_i) cache_sel_q <= 1'b0;
      else if (grant_d) cache_sel_q <= 1'b1;
      if (pmem_resp && (state_q == IDLE || state_q == TURNAROUND)) spurious_q <= 1'b1;
    end
  end

  assign cache_sel     = cache_sel_q;
  assign mem_en        = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign busy          = (state_q != IDLE);
  assign spurious_resp = spurious_q;
  assign state_dbg     = state_q;

`ifdef ARB_PERF_EN
  logic [CNT_WIDTH-1:0] i_cnt_q, d_cnt_q, cont_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt_q    <= '0;
      d_cnt_q    <= '0;
      cont_cnt_q <= '0;
    end else begin
      if (grant_i) i_cnt_q <= i_cnt_q + 1'b1;
      if (grant_d) d_cnt_q <= d_cnt_q + 1'b1;
      if ((grant_i || grant_d) && tie) cont_cnt_q <= cont_cnt_q + 1'b1;
    end
  end

  assign i_grant_cnt    = i_cnt_q;
  assign d_grant_cnt    = d_cnt_q;
  assign contention_cnt = cont_cnt_q;
`endif

endmodule

// File: tb/tb_arbiter_control.sv
// Directed bench for arbiter_control: a fixed-priority instance (ARB_MODE=1) and a
// round-robin instance (ARB_MODE=0) run in lockstep on shared inputs.
module tb_arbiter_control;

  logic clk, rst, iread, dread, dwrite, pmem_resp;
  logic cache_sel, mem_en, busy, spurious_resp;
  logic rr_cache_sel, rr_mem_en, rr_busy, rr_spurious_resp;
  logic [1:0] state_dbg, rr_state_dbg;
`ifdef ARB_PERF_EN
  logic [31:0] i_grant_cnt, d_grant_cnt, contention_cnt;
  logic [31:0] rr_i_grant_cnt, rr_d_grant_cnt, rr_contention_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_rr_q[$];

  arbiter_control #(.ARB_MODE(1), .STARVE_LIMIT(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .iread(iread), .dread(dread), .dwrite(dwrite),
    .pmem_resp(pmem_resp), .cache_sel(cache_sel), .mem_en(mem_en), .busy(busy),
    .spurious_resp(spurious_resp),
`ifdef ARB_PERF_EN
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .contention_cnt(contention_cnt),
`endif
    .state_dbg(state_dbg)
  );

  arbiter_control #(.ARB_MODE(0), .STARVE_LIMIT(4), .CNT_WIDTH(32)) dut_rr (
    .clk(clk), .rst(rst), .iread(iread), .dread(dread), .dwrite(dwrite),
    .pmem_resp(pmem_resp), .cache_sel(rr_cache_sel), .mem_en(rr_mem_en), .busy(rr_busy),
    .spurious_resp(rr_spurious_resp),
`ifdef ARB_PERF_EN
    .i_grant_cnt(rr_i_grant_cnt), .d_grant_cnt(rr_d_grant_cnt),
    .contention_cnt(rr_contention_cnt),
`endif
    .state_dbg(rr_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_grant(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (mem_en) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic do_txn(input logic is_d);
    iread = ~is_d;
    dread = is_d;
    wait_grant("txn_grant");
    check("txn_sel", {31'd0, cache_sel}, {31'd0, is_d});
    tick();
    pmem_resp = 1'b1;
    iread = 1'b0;
    dread = 1'b0;
    tick();
    pmem_resp = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; iread = 1'b0; dread = 1'b0; dwrite = 1'b0; pmem_resp = 1'b0;
    tick();
    check("rst_cache_sel", {31'd0, cache_sel}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_spurious", {31'd0, spurious_resp}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // I alone: grant one cycle after the request, held until resp, turnaround, idle
    iread = 1'b1;
    tick();
    check("i_grant_mem_en", {31'd0, mem_en}, 32'd1);
    check("i_grant_sel", {31'd0, cache_sel}, 32'd0);
    check("i_grant_state", {30'd0, state_dbg}, 32'd1);
    tick(); tick(); tick();
    check("i_hold_mem_en", {31'd0, mem_en}, 32'd1);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    iread = 1'b0;
    check("i_ta_mem_en", {31'd0, mem_en}, 32'd0);
    check("i_ta_busy", {31'd0, busy}, 32'd1);
    check("i_ta_state", {30'd0, state_dbg}, 32'd3);
    tick();
    check("i_idle_busy", {31'd0, busy}, 32'd0);

    // D write-back, I raised mid-transaction waits for turnaround
    dwrite = 1'b1;
    tick();
    check("d_grant_sel", {31'd0, cache_sel}, 32'd1);
    check("d_grant_mem_en", {31'd0, mem_en}, 32'd1);
    iread = 1'b1;
    tick();
    check("d_mid_sel", {31'd0, cache_sel}, 32'd1);
    check("d_mid_state", {30'd0, state_dbg}, 32'd2);
    pmem_resp = 1'b1;
    dwrite = 1'b0;
    tick();
    pmem_resp = 1'b0;
    check("d_ta_sel", {31'd0, cache_sel}, 32'd1);
    check("d_ta_mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    check("d_then_idle", {30'd0, state_dbg}, 32'd0);
    tick();
    check("d_then_i_sel", {31'd0, cache_sel}, 32'd0);
    check("d_then_i_mem_en", {31'd0, mem_en}, 32'd1);
    pmem_resp = 1'b1;
    iread = 1'b0;
    tick();
    pmem_resp = 1'b0;
    tick();
    check("spurious_clean", {31'd0, spurious_resp}, 32'd0);

    // Reset, then both held: starvation guard vs round-robin grant order
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_q    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_rr_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    iread = 1'b1;
    dread = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_grant("tie_grant");
      check("starve_order", {31'd0, cache_sel}, {31'd0, exp_q.pop_front()});
      check("rr_order", {31'd0, rr_cache_sel}, {31'd0, exp_rr_q.pop_front()});
      tick();
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
    end
    iread = 1'b0;
    dread = 1'b0;
    tick();
`ifdef ARB_PERF_EN
    check("perf_i_tie", i_grant_cnt, 32'd2);
    check("perf_d_tie", d_grant_cnt, 32'd8);
    check("perf_cont_tie", contention_cnt, 32'd10);
    check("rr_perf_i_tie", rr_i_grant_cnt, 32'd5);
    check("rr_perf_d_tie", rr_d_grant_cnt, 32'd5);
`endif

    // Asynchronous reset while serving D
    dwrite = 1'b1;
    tick();
    check("pre_rst_state", {30'd0, state_dbg}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sel", {31'd0, cache_sel}, 32'd0);
    check("async_rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_rr_mem_en", {31'd0, rr_mem_en}, 32'd0);
    dwrite = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Spurious response in IDLE is sticky and grants nothing
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check("spurious_set", {31'd0, spurious_resp}, 32'd1);
    check("spurious_no_grant", {31'd0, mem_en}, 32'd0);
    tick(); tick();
    check("spurious_sticky", {31'd0, spurious_resp}, 32'd1);
    check("spurious_rr", {31'd0, rr_spurious_resp}, 32'd1);
    check("spurious_idle", {31'd0, busy}, 32'd0);

    // Separate transactions: 3 I + 2 D
    do_txn(1'b0);
    do_txn(1'b1);
    do_txn(1'b0);
    do_txn(1'b1);
    do_txn(1'b0);
`ifdef ARB_PERF_EN
    check("perf_i_cnt", i_grant_cnt, 32'd3);
    check("perf_d_cnt", d_grant_cnt, 32'd2);
    check("perf_cont_cnt", contention_cnt, 32'd0);
`endif
    check("final_idle", {31'd0, busy}, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
